axi_wr_dispatch: RTL and testbench
==================================

Name: axi_wr_dispatch

Overview:
- Sequences each accepted AXI write beat from the AXI write interface into one of three targets: the command FIFO, IRAM or WRAM.
- Decodes the region and drives the target's write handshake, then returns exactly one completion pulse per beat (fifo_wr_done / iram_wr_done / wram_wr_done, plus fifo_err).
- The AXI write interface stalls WREADY until that pulse; this block owns all target-side write timing.

Parameters:
- ADDR_W, 11, byte address width of axi_wr_addr
- DATA_W, 32, write data width
- STRB_W, 4, byte-strobe width (DATA_W/8)
- TIMEOUT_CYCLES, 255, watchdog limit in ISSUE state (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- axi_wr_vld  in  1  one-cycle beat valid from the AXI write interface
- axi_wr_addr  in  ADDR_W  beat byte address
- axi_wr_data  in  DATA_W  beat data
- axi_wr_strb  in  STRB_W  beat byte strobes
- axi_wr_region  in  2  target select: 00 FIFO, 01 IRAM, 10 WRAM, 11 invalid
- fifo_full  in  1  FIFO cannot accept a push
- fifo_push  out  1  one-cycle FIFO push strobe
- fifo_wdata  out  DATA_W  FIFO push data
- iram_req  out  1  IRAM write request, held until iram_ack
- iram_ack  in  1  IRAM write accepted
- wram_req  out  1  WRAM write request, held until wram_ack
- wram_ack  in  1  WRAM write accepted
- ram_addr  out  ADDR_W-2  word address (axi_wr_addr[ADDR_W-1:2]), shared by IRAM and WRAM
- ram_wdata  out  DATA_W  RAM write data
- ram_wstrb  out  STRB_W  RAM byte strobes
- fifo_wr_done  out  1  completion pulse: FIFO beat, or any error completion
- fifo_err  out  1  error qualifier, valid only together with fifo_wr_done
- iram_wr_done  out  1  IRAM completion pulse
- wram_wr_done  out  1  WRAM completion pulse
- dispatch_ovf  out  1  sticky: axi_wr_vld was seen while busy

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE immediately.
  - All outputs go to 0, including dispatch_ovf; capture registers are cleared.
  - A reset mid-transfer drops the beat and immediately deasserts any req/push; no done pulse is issued.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - On axi_wr_vld=1, capture addr/data/strb/region into registers, then go to ISSUE on the next cycle.
- ISSUE, by captured region:
  - 00: if fifo_full=0, fifo_push=1 for exactly one cycle with fifo_wdata=captured data, then go to DONE. If fifo_full=1, stay in ISSUE with fifo_push=0.
  - 01/10: iram_req or wram_req is asserted from ISSUE entry and held stable, with ram_addr/ram_wdata/ram_wstrb stable, until ack is sampled high. Then deassert req the following cycle and go to DONE. An ack sampled while req=0 is ignored.
  - 11: push/req is never asserted; go directly to DONE with the error flag set.
- DONE:
  - Issue one registered one-cycle pulse on exactly one done output, then return to IDLE.
  - For 11 (and timeout): fifo_wr_done=1 and fifo_err=1.
  - For 00: fifo_wr_done=1, fifo_err=0.
- Minimum latency: axi_wr_vld at cycle N → FIFO push at N+1 → done at N+2. RAM with ack in the first ISSUE cycle gives the same timing.
- axi_wr_vld in ISSUE or DONE: the beat is ignored and dispatch_ovf is set. dispatch_ovf stays set until reset.
- axi_wr_vld in the same cycle as a DONE pulse: counts as busy, so it is ignored and sets dispatch_ovf. Upstream never does this.
- At most one of fifo_push/iram_req/wram_req is high in any cycle. At most one done pulse is high in any cycle.
- ram_wstrb is passed through unmodified; all-zero strobes still perform the handshake.

Optional Feature:
- Macro: AXI_WR_DISP_TIMEOUT_EN
- When defined:
  - An 8-bit-or-wider counter clears on ISSUE entry and increments each cycle spent in ISSUE.
  - On reaching TIMEOUT_CYCLES, req/push is dropped, no push occurs, and the FSM goes to DONE with fifo_wr_done=1, fifo_err=1, whatever the target.
- When not defined:
  - No counter exists; ISSUE waits indefinitely on fifo_full or ack.

Test Plan:
- Region 00, fifo_full=0, data 0xDEADBEEF at cycle 10 → fifo_push=1 with fifo_wdata=0xDEADBEEF at cycle 11; fifo_wr_done=1, fifo_err=0 at cycle 12 only.
- Region 01, addr 0x104, strb 0x3, iram_ack delayed 3 cycles → iram_req high 4 cycles, ram_addr=0x41, ram_wstrb=0x3 stable; iram_wr_done single pulse; wram_req never high.
- Region 00 with fifo_full=1 for 5 cycles → no push during the full window; push in the first cycle after fifo_full falls; then one fifo_wr_done.
- Region 11 → no push/req; fifo_wr_done=1 with fifo_err=1 two cycles after vld.
- Second axi_wr_vld during WRAM wait → ignored; dispatch_ovf=1 and stays 1; only one wram_wr_done. Then assert rst_n=0 mid-wait → wram_req and dispatch_ovf drop to 0 immediately, FSM returns to IDLE.
- With AXI_WR_DISP_TIMEOUT_EN and TIMEOUT_CYCLES=16, region 10 with no ack → wram_req drops after 16 ISSUE cycles; fifo_wr_done=1, fifo_err=1; no wram_wr_done.

Source files
------------

// File: rtl/axi_wr_dispatch_if.sv
// Bundle of the AXI-write beat input and the FIFO/IRAM/WRAM write sides of axi_wr_dispatch.
// slave = dispatcher view, master = upstream/target environment view.
interface axi_wr_dispatch_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int STRB_W = 4
);
  logic              axi_wr_vld;
  logic [ADDR_W-1:0] axi_wr_addr;
  logic [DATA_W-1:0] axi_wr_data;
  logic [STRB_W-1:0] axi_wr_strb;
  logic [1:0]        axi_wr_region;
  logic              fifo_full;
  logic              fifo_push;
  logic [DATA_W-1:0] fifo_wdata;
  logic              iram_req;
  logic              iram_ack;
  logic              wram_req;
  logic              wram_ack;
  logic [ADDR_W-3:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [STRB_W-1:0] ram_wstrb;
  logic              fifo_wr_done;
  logic              fifo_err;
  logic              iram_wr_done;
  logic              wram_wr_done;
  logic              dispatch_ovf;

  modport slave (
    input  axi_wr_vld, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region,
           fifo_full, iram_ack, wram_ack,
    output fifo_push, fifo_wdata, iram_req, wram_req, ram_addr, ram_wdata, ram_wstrb,
           fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done, dispatch_ovf
  );

  modport master (
    output axi_wr_vld, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region,
           fifo_full, iram_ack, wram_ack,
    input  fifo_push, fifo_wdata, iram_req, wram_req, ram_addr, ram_wdata, ram_wstrb,
           fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done, dispatch_ovf
  );
endinterface

// File: rtl/axi_wr_dispatch.sv
// Routes one AXI write beat at a time to the command FIFO, IRAM or WRAM and returns one done pulse.
// Optional ISSUE watchdog enabled by defining AXI_WR_DISP_TIMEOUT_EN.
module axi_wr_dispatch #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 32,
  parameter int STRB_W         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_wr_dispatch_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [1:0] RG_FIFO = 2'b00;
  localparam logic [1:0] RG_IRAM = 2'b01;
  localparam logic [1:0] RG_WRAM = 2'b10;

  state_t            state;
  logic [1:0]        cap_region;
  logic [ADDR_W-3:0] cap_waddr;
  logic [DATA_W-1:0] cap_data;
  logic [STRB_W-1:0] cap_strb;
  logic              iram_req_q, wram_req_q;
  logic              fdone_q, ferr_q, idone_q, wdone_q, ovf_q;
  logic              issue_ok;
  logic              tmo_hit;

  // Byte-lane bits of the address do not reach the word-addressed RAMs.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.axi_wr_addr[1:0];

`ifdef AXI_WR_DISP_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  // Counter holds (ISSUE cycles - 1); fires on the TIMEOUT_CYCLES-th ISSUE cycle.
  assign tmo_hit = (state == ISSUE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Target accepted the beat this cycle (invalid region completes immediately).
  always_comb begin
    issue_ok = 1'b0;
    case (cap_region)
      RG_FIFO: issue_ok = !bus.fifo_full;
      RG_IRAM: issue_ok = iram_req_q && bus.iram_ack;
      RG_WRAM: issue_ok = wram_req_q && bus.wram_ack;
      default: issue_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_region <= '0;
      cap_waddr  <= '0;
      cap_data   <= '0;
      cap_strb   <= '0;
      iram_req_q <= 1'b0;
      wram_req_q <= 1'b0;
      fdone_q    <= 1'b0;
      ferr_q     <= 1'b0;
      idone_q    <= 1'b0;
      wdone_q    <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef AXI_WR_DISP_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      fdone_q <= 1'b0;
      ferr_q  <= 1'b0;
      idone_q <= 1'b0;
      wdone_q <= 1'b0;
      if (bus.axi_wr_vld && state != IDLE) ovf_q <= 1'b1;
      case (state)
        IDLE: if (bus.axi_wr_vld) begin
          cap_region <= bus.axi_wr_region;
          cap_waddr  <= bus.axi_wr_addr[ADDR_W-1:2];
          cap_data   <= bus.axi_wr_data;
          cap_strb   <= bus.axi_wr_strb;
          iram_req_q <= (bus.axi_wr_region == RG_IRAM);
          wram_req_q <= (bus.axi_wr_region == RG_WRAM);
`ifdef AXI_WR_DISP_TIMEOUT_EN
          tmo_cnt    <= '0;
`endif
          state      <= ISSUE;
        end
        ISSUE: begin
`ifdef AXI_WR_DISP_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
          // A real completion in the watchdog's last cycle still counts as success.
          if (issue_ok || tmo_hit) begin
            iram_req_q <= 1'b0;
            wram_req_q <= 1'b0;
            fdone_q    <= !issue_ok || cap_region == RG_FIFO || cap_region == 2'b11;
            ferr_q     <= !issue_ok || cap_region == 2'b11;
            idone_q    <= issue_ok && cap_region == RG_IRAM;
            wdone_q    <= issue_ok && cap_region == RG_WRAM;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Push qualifies on the live fifo_full so a full FIFO is never pushed.
  assign bus.fifo_push    = (state == ISSUE) && (cap_region == RG_FIFO) && !bus.fifo_full;
  assign bus.fifo_wdata   = cap_data;
  assign bus.iram_req     = iram_req_q;
  assign bus.wram_req     = wram_req_q;
  assign bus.ram_addr     = cap_waddr;
  assign bus.ram_wdata    = cap_data;
  assign bus.ram_wstrb    = cap_strb;
  assign bus.fifo_wr_done = fdone_q;
  assign bus.fifo_err     = ferr_q;
  assign bus.iram_wr_done = idone_q;
  assign bus.wram_wr_done = wdone_q;
  assign bus.dispatch_ovf = ovf_q;
endmodule

// File: tb/tb_axi_wr_dispatch.sv
// Directed-vector bench for axi_wr_dispatch: each row is a beat plus per-cycle target stimulus and
// hand-computed per-cycle output traces (bit i = cycle i after the vld cycle).
module tb_axi_wr_dispatch;
  localparam int WIN = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axi_wr_dispatch_if #(.ADDR_W(11), .DATA_W(32), .STRB_W(4)) bus ();

  axi_wr_dispatch #(.ADDR_W(11), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  region;
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] vld, full, iack, wack;
    logic [31:0] e_push, e_ireq, e_wreq, e_fdone, e_ferr, e_idone, e_wdone;
    logic        e_ovf;
  } row_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic row_t mk(input logic [1:0] rg, input logic [10:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] v, f, ia, wa,
                              input logic [31:0] p, ir, wr, fd, fe, id, wd, input logic ov);
    row_t r;
    r.region = rg; r.addr = a; r.data = d; r.strb = s;
    r.vld = v; r.full = f; r.iack = ia; r.wack = wa;
    r.e_push = p; r.e_ireq = ir; r.e_wreq = wr; r.e_fdone = fd; r.e_ferr = fe;
    r.e_idone = id; r.e_wdone = wd; r.e_ovf = ov;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.axi_wr_vld = 1'b0; bus.axi_wr_addr = '0; bus.axi_wr_data = '0; bus.axi_wr_strb = '0;
    bus.axi_wr_region = '0; bus.fifo_full = 1'b0; bus.iram_ack = 1'b0; bus.wram_ack = 1'b0;
  endtask

  // Entered and left at posedge+1.
  task automatic run_row(input string name, input row_t r);
    logic [31:0] t_push, t_ireq, t_wreq, t_fd, t_fe, t_id, t_wd;
    logic        bad;
    logic [8:0]  waddr;
    t_push = '0; t_ireq = '0; t_wreq = '0; t_fd = '0; t_fe = '0; t_id = '0; t_wd = '0;
    bad = 1'b0;
    waddr = r.addr[10:2];
    for (int i = 0; i < WIN; i++) begin
      bus.axi_wr_vld    = r.vld[i];
      bus.axi_wr_addr   = (i == 0) ? r.addr : ~r.addr;
      bus.axi_wr_data   = (i == 0) ? r.data : ~r.data;
      bus.axi_wr_strb   = (i == 0) ? r.strb : ~r.strb;
      bus.axi_wr_region = r.region;
      bus.fifo_full     = r.full[i];
      bus.iram_ack      = r.iack[i];
      bus.wram_ack      = r.wack[i];
      @(negedge clk);
      t_push[i] = bus.fifo_push;    t_ireq[i] = bus.iram_req;     t_wreq[i] = bus.wram_req;
      t_fd[i]   = bus.fifo_wr_done; t_fe[i]   = bus.fifo_err;
      t_id[i]   = bus.iram_wr_done; t_wd[i]   = bus.wram_wr_done;
      if ((bus.iram_req || bus.wram_req) &&
          (bus.ram_addr !== waddr || bus.ram_wstrb !== r.strb || bus.ram_wdata !== r.data)) bad = 1'b1;
      if (bus.fifo_push && bus.fifo_wdata !== r.data) bad = 1'b1;
      @(posedge clk); #1;
    end
    idle_inputs();
    chk({name, ".push"},  t_push, r.e_push);
    chk({name, ".ireq"},  t_ireq, r.e_ireq);
    chk({name, ".wreq"},  t_wreq, r.e_wreq);
    chk({name, ".fdone"}, t_fd,   r.e_fdone);
    chk({name, ".ferr"},  t_fe,   r.e_ferr);
    chk({name, ".idone"}, t_id,   r.e_idone);
    chk({name, ".wdone"}, t_wd,   r.e_wdone);
    chk({name, ".stable"}, {31'd0, bad}, 32'd0);
    chk({name, ".ovf"},   {31'd0, bus.dispatch_ovf}, {31'd0, r.e_ovf});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".strobes"}, {25'd0, bus.fifo_push, bus.iram_req, bus.wram_req, bus.fifo_wr_done,
                            bus.fifo_err, bus.iram_wr_done, bus.wram_wr_done}, 32'd0);
    chk({tag, ".ovf"},     {31'd0, bus.dispatch_ovf}, 32'd0);
    chk({tag, ".ram_addr"}, {23'd0, bus.ram_addr}, 32'd0);
    chk({tag, ".ram_data"}, bus.ram_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_row("fifo",   mk(2'b00, 11'h010, 32'hDEADBEEF, 4'hF, 32'h1, 32'h0, 32'h0, 32'h0,
                         32'h2, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b0));
    run_row("iram",   mk(2'b01, 11'h104, 32'h12345678, 4'h3, 32'h1, 32'h0, 32'h10, 32'h0,
                         32'h0, 32'h1E, 32'h0, 32'h0, 32'h0, 32'h20, 32'h0, 1'b0));
    run_row("full",   mk(2'b00, 11'h020, 32'hCAFEF00D, 4'hF, 32'h1, 32'h3F, 32'h0, 32'h0,
                         32'h40, 32'h0, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0, 1'b0));
    run_row("inval",  mk(2'b11, 11'h7FC, 32'hA5A5A5A5, 4'hF, 32'h1, 32'h0, 32'hFF, 32'hFF,
                         32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h0, 32'h0, 1'b0));
    run_row("wram0",  mk(2'b10, 11'h7FC, 32'h0BADCAFE, 4'hC, 32'h1, 32'h0, 32'h0, 32'h2,
                         32'h0, 32'h0, 32'h2, 32'h0, 32'h0, 32'h0, 32'h4, 1'b0));
    run_row("wstrb0", mk(2'b10, 11'h008, 32'h11111111, 4'h0, 32'h1, 32'h0, 32'h0, 32'h8,
                         32'h0, 32'h0, 32'hE, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0));
    run_row("iack_x", mk(2'b01, 11'h3FC, 32'h89ABCDEF, 4'h5, 32'h1, 32'h0, 32'h15, 32'h0,
                         32'h0, 32'h6, 32'h0, 32'h0, 32'h0, 32'h8, 32'h0, 1'b0));
`ifdef AXI_WR_DISP_TIMEOUT_EN
    run_row("tmo",    mk(2'b10, 11'h100, 32'h55AA55AA, 4'hF, 32'h1, 32'h0, 32'h0, 32'h0,
                         32'h0, 32'h0, 32'h1FFFE, 32'h20000, 32'h20000, 32'h0, 32'h0, 1'b0));
`endif
    // Extra vld while waiting on WRAM and again in the DONE cycle.
    run_row("ovf",    mk(2'b10, 11'h0C4, 32'hFEEDFACE, 4'h9, 32'h25, 32'h0, 32'h0, 32'h10,
                         32'h0, 32'h0, 32'h1E, 32'h0, 32'h0, 32'h0, 32'h20, 1'b1));

    // Async reset in the middle of a WRAM wait.
    bus.axi_wr_vld = 1'b1; bus.axi_wr_region = 2'b10; bus.axi_wr_addr = 11'h040;
    bus.axi_wr_data = 32'h0F0F0F0F; bus.axi_wr_strb = 4'hF;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("mid.wreq_before", {31'd0, bus.wram_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("post_rst");

    run_row("fifo2",  mk(2'b00, 11'h1F0, 32'h600DF00D, 4'hF, 32'h1, 32'h0, 32'h0, 32'h0,
                         32'h2, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
